// File: rtl/hram_pkg.sv
// HyperRAM controller shared types and timing constants.
// Holds the FSM state enum, CA bit positions, edge counts and CA builder.
package hram_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CS_SETUP,
    CA,
    LATENCY,
    DATA,
    CS_HOLD
  } state_t;

  localparam int CA_RW     = 47;
  localparam int CA_AS     = 46;
  localparam int CA_BURST  = 45;
  localparam int CA_ROW_HI = 44;
  localparam int CA_ROW_LO = 16;
  localparam int CA_COL_HI = 2;

  localparam int CA_EDGES   = 6;
  localparam int LAT_SHORT  = 6;
  localparam int LAT_LONG   = 14;
  localparam int REGW_EDGES = 8;

  function automatic logic [47:0] ca_word(
    input logic        wr,
    input logic        rs,
    input logic [31:0] a
  );
    logic [47:0] c;
    c = '0;
    c[CA_RW] = ~wr;
    c[CA_AS] = rs;
    c[CA_BURST] = 1'b1;
    c[CA_ROW_HI:CA_ROW_LO] = a[31:3];
    c[CA_COL_HI:0] = a[2:0];
    return c;
  endfunction

endpackage

// File: rtl/hram_ctrl.sv
// HyperRAM single-word controller: request/response port to HyperBus.
// Ports: req_* in, resp_* out, hram_* bus pins with tristate split.
module hram_ctrl
  import hram_pkg::*;
(
  input  logic        clk,
  input  logic        resetn,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic        req_reg,
  input  logic [31:0] req_addr,
  input  logic [15:0] req_wdata,
  input  logic [1:0]  req_wstrb,
  output logic        resp_valid,
  output logic [15:0] resp_rdata,
  output logic        hram_cs,
  output logic        hram_ck,
  output logic        hram_rwds_oe,
  output logic        hram_rwds_dout,
  input  logic        hram_rwds_din,
  output logic        hram_dq_oe,
  output logic [7:0]  hram_dq_dout,
  input  logic [7:0]  hram_dq_din
);

  state_t      state_q, state_d;
  logic [4:0]  edge_q, edge_d;
  logic        ph_q, ph_d;
  logic        ck_q, ck_d;
  logic [47:0] ca_q;
  logic        write_q, reg_q, long_q;
  logic [15:0] wdata_q, rbuf_q, rdata_q;
  logic [1:0]  wstrb_q;
  logic        resp_q;

  logic        active, regw, first;
  logic [4:0]  edge_nx, dat_first;

  assign active = (state_q == CA) ||
                  (state_q == LATENCY) ||
                  (state_q == DATA);
  assign regw = write_q & reg_q;
  assign edge_nx = edge_q + 5'd1;
  // First data edge; register writes skip the latency phase.
  assign dat_first = regw ? 5'(REGW_EDGES - 2) :
                     long_q ? 5'(CA_EDGES + LAT_LONG) :
                              5'(CA_EDGES + LAT_SHORT);
  assign first = (edge_q == dat_first);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      edge_q  <= '0;
      ph_q    <= 1'b0;
      ck_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      edge_q  <= edge_d;
      ph_q    <= ph_d;
      ck_q    <= ck_d;
    end
  end

  // ph_q: 0 = launch cycle, 1 = toggle cycle of the current edge.
  always_comb begin
    state_d = state_q;
    edge_d  = edge_q;
    ph_d    = ph_q;
    ck_d    = ck_q ^ (active & ~ph_q);
    unique case (state_q)
      IDLE: begin
        if (req_valid) state_d = CS_SETUP;
      end
      CS_SETUP: begin
        state_d = CA;
        edge_d  = '0;
        ph_d    = 1'b0;
      end
      CA, LATENCY, DATA: begin
        ph_d = ~ph_q;
        if (ph_q) begin
          edge_d = edge_nx;
          if (edge_nx == dat_first + 5'd2)
            state_d = CS_HOLD;
          else if (edge_nx == dat_first)
            state_d = DATA;
          else if (edge_nx == 5'(CA_EDGES))
            state_d = LATENCY;
        end
      end
      CS_HOLD: begin
        ph_d = ~ph_q;
        if (ph_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    req_ready      = (state_q == IDLE);
    hram_cs        = (state_q == IDLE);
    hram_dq_oe     = 1'b0;
    hram_dq_dout   = '0;
    hram_rwds_oe   = 1'b0;
    hram_rwds_dout = 1'b0;
    if (state_q == CA) begin
      hram_dq_oe   = 1'b1;
      hram_dq_dout = ca_q[47:40];
    end else if (state_q == DATA && write_q) begin
      hram_dq_oe   = 1'b1;
      hram_dq_dout = first ? wdata_q[15:8] : wdata_q[7:0];
      if (!reg_q) begin
        hram_rwds_oe   = 1'b1;
        hram_rwds_dout = first ? wstrb_q[1] : wstrb_q[0];
      end
    end
  end

  assign hram_ck    = ck_q;
  assign resp_valid = resp_q;
  assign resp_rdata = rdata_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ca_q    <= '0;
      write_q <= 1'b0;
      reg_q   <= 1'b0;
      long_q  <= 1'b0;
      wdata_q <= '0;
      wstrb_q <= '0;
      rbuf_q  <= '0;
      rdata_q <= '0;
      resp_q  <= 1'b0;
    end else begin
      resp_q <= (state_q == CS_HOLD) && ph_q;
      if (state_q == IDLE && req_valid) begin
        ca_q    <= ca_word(req_write, req_reg, req_addr);
        write_q <= req_write;
        reg_q   <= req_reg;
        wdata_q <= req_wdata;
        wstrb_q <= req_wstrb;
      end else if (state_q == CA && ph_q) begin
        ca_q <= ca_q << 8;
      end
      if (state_q == CA && !ph_q && edge_q == '0)
        long_q <= hram_rwds_din;
      // Each byte is taken in the launch slot after its bus edge.
      if (state_q == DATA && !ph_q &&
          edge_q == dat_first + 5'd1)
        rbuf_q[15:8] <= hram_dq_din;
      if (state_q == CS_HOLD && !ph_q)
        rbuf_q[7:0] <= hram_dq_din;
      if (state_q == CS_HOLD && ph_q && !write_q)
        rdata_q <= rbuf_q;
    end
  end

endmodule
